tpu_int_ctrl: RTL and testbench

Interrupt controller directly downstream of the TPU timer. It takes the timer's TPUINT plus other TPU interrupt lines, edge-detects and latches them into pending bits, and arbitrates them by fixed priority. It presents one request at a time to the CPU with an ACK/EOI handshake and timestamps each request with the timer's TIME. It drives INTFLAG back to the timer, so the timer's TPUINT is held until software services the interrupt.

---
 rtl/tpu_int_ctrl.sv | 123 ++++++++++++
 tb/tb_tpu_int_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_int_ctrl.sv
// Interrupt controller for the TPU timer: edge-latched pending bits, fixed-priority
// arbitration, and a single outstanding request with an ACK/EOI handshake.

module tpu_int_src_cell (
   input  logic SYS_CLK,
   input  logic RST,
   input  logic src,
   input  logic clr,
   output logic pend
);
   logic src_d;

   // A fresh rise outranks a simultaneous clear so no event is lost.
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         src_d <= 1'b0;
         pend  <= 1'b0;
      end else begin
         src_d <= src;
         if (src & ~src_d)
            pend <= 1'b1;
         else if (clr)
            pend <= 1'b0;
      end
   end
endmodule

module tpu_int_ctrl #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic               SYS_CLK,
   input  logic               RST,
   input  logic [NUM_SRC-1:0] SRC_IRQ,
   input  logic [6:0]         TIME,
   input  logic               MASK_WE,
   input  logic [NUM_SRC-1:0] MASK_WDATA,
   input  logic               CLR_WE,
   input  logic [NUM_SRC-1:0] CLR_WDATA,
   input  logic               CPU_ACK,
   input  logic               CPU_EOI,
   output logic               IRQ,
   output logic [ID_W-1:0]    IRQ_ID,
   output logic [6:0]         IRQ_STAMP,
   output logic [NUM_SRC-1:0] PENDING,
   output logic [NUM_SRC-1:0] MASK,
   output logic               INTFLAG
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t             state, state_nxt;
   logic [ID_W-1:0]    id_nxt, winner;
   logic [6:0]         stamp_nxt;
   logic [NUM_SRC-1:0] eligible, ack_vec, clr_vec;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         tpu_int_src_cell u_cell (
            .SYS_CLK (SYS_CLK),
            .RST     (RST),
            .src     (SRC_IRQ[g]),
            .clr     (clr_vec[g]),
            .pend    (PENDING[g])
         );
      end
   endgenerate

   assign eligible = PENDING & MASK;

   // Walk downward so the lowest eligible index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (eligible[i]) winner = ID_W'(i);
   end

   always_comb begin
      ack_vec = '0;
      if (state == S_REQ && CPU_ACK) ack_vec[IRQ_ID] = 1'b1;
      clr_vec = (CLR_WE ? CLR_WDATA : '0) | ack_vec;
   end

   always_comb begin
      state_nxt = state;
      id_nxt    = IRQ_ID;
      stamp_nxt = IRQ_STAMP;
      case (state)
         S_IDLE:
            if (|eligible) begin
               state_nxt = S_REQ;
               id_nxt    = winner;
               stamp_nxt = TIME;
            end
         S_REQ:
            if (CPU_ACK)
               state_nxt = S_SERVICE;
            else if (!eligible[IRQ_ID])
               state_nxt = S_IDLE;
         S_SERVICE:
            if (CPU_EOI) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         IRQ_ID    <= '0;
         IRQ_STAMP <= '0;
         MASK      <= '0;
      end else begin
         state     <= state_nxt;
         IRQ_ID    <= id_nxt;
         IRQ_STAMP <= stamp_nxt;
         if (MASK_WE) MASK <= MASK_WDATA;
      end
   end

   assign IRQ     = (state == S_REQ);
   assign INTFLAG = PENDING[0] | (state == S_SERVICE && IRQ_ID == '0);
endmodule

// File: tb/tb_tpu_int_ctrl.sv
// Directed plus randomized bench for tpu_int_ctrl against a cycle-level reference model.

module tb_tpu_int_ctrl;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          SYS_CLK = 1'b0;
   logic          RST;
   logic [N-1:0]  SRC_IRQ;
   logic [6:0]    TIME;
   logic          MASK_WE, CLR_WE, CPU_ACK, CPU_EOI;
   logic [N-1:0]  MASK_WDATA, CLR_WDATA;
   logic          IRQ, INTFLAG;
   logic [IW-1:0] IRQ_ID;
   logic [6:0]    IRQ_STAMP;
   logic [N-1:0]  PENDING, MASK;

   tpu_int_ctrl #(.NUM_SRC(N), .ID_W(IW)) dut (
      .SYS_CLK(SYS_CLK), .RST(RST), .SRC_IRQ(SRC_IRQ), .TIME(TIME),
      .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA), .CLR_WE(CLR_WE), .CLR_WDATA(CLR_WDATA),
      .CPU_ACK(CPU_ACK), .CPU_EOI(CPU_EOI), .IRQ(IRQ), .IRQ_ID(IRQ_ID),
      .IRQ_STAMP(IRQ_STAMP), .PENDING(PENDING), .MASK(MASK), .INTFLAG(INTFLAG)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: pending set, mask, and whether a request is outstanding / being serviced.
   bit [N-1:0] m_pend, m_mask, m_prev;
   bit         m_asking, m_serving;
   int         m_id, m_stamp;
   int         n_raise;
   bit         irq_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit [N-1:0] rise, elig, kill;
      if (RST) begin
         m_pend = '0; m_mask = '0; m_prev = '0;
         m_asking = 0; m_serving = 0; m_id = 0; m_stamp = 0;
         return;
      end
      rise = SRC_IRQ & ~m_prev;
      elig = m_pend & m_mask;
      kill = CLR_WE ? CLR_WDATA : '0;
      if (m_asking) begin
         if (CPU_ACK) begin
            kill[m_id] = 1'b1;
            m_asking = 0; m_serving = 1;
         end else if (!elig[m_id]) m_asking = 0;
      end else if (m_serving) begin
         if (CPU_EOI) m_serving = 0;
      end else if (elig != '0) begin
         for (int i = 0; i < N; i++)
            if (elig[i]) begin m_id = i; break; end
         m_stamp  = TIME;
         m_asking = 1;
      end
      m_pend = (m_pend & ~kill) | rise;
      if (MASK_WE) m_mask = MASK_WDATA;
      m_prev = SRC_IRQ;
   endtask

   task automatic check_all();
      chk("IRQ",       IRQ,       m_asking);
      chk("IRQ_ID",    IRQ_ID,    m_id);
      chk("IRQ_STAMP", IRQ_STAMP, m_stamp);
      chk("PENDING",   PENDING,   m_pend);
      chk("MASK",      MASK,      m_mask);
      chk("INTFLAG",   INTFLAG,   m_pend[0] | (m_serving && m_id == 0));
   endtask

   task automatic tick();
      @(posedge SYS_CLK);
      model_step();
      #1;
      check_all();
      if (IRQ && !irq_seen) n_raise++;
      irq_seen = IRQ;
      TIME = TIME + 7'd1;
   endtask

   task automatic quiet();
      MASK_WE = 0; CLR_WE = 0; CPU_ACK = 0; CPU_EOI = 0;
   endtask

   task automatic wr_mask(input logic [N-1:0] m);
      MASK_WE = 1; MASK_WDATA = m; tick(); MASK_WE = 0;
   endtask

   task automatic ack_eoi();
      CPU_ACK = 1; tick(); CPU_ACK = 0;
      CPU_EOI = 1; tick(); CPU_EOI = 0;
   endtask

   initial begin
      RST = 1; SRC_IRQ = '0; TIME = '0; MASK_WDATA = '0; CLR_WDATA = '0;
      irq_seen = 0; n_raise = 0;
      quiet();
      tick(); tick();
      RST = 0;
      tick();

      // Timer source, stamp and handshake.
      wr_mask(4'b0001);
      SRC_IRQ = 4'b0001; tick();
      chk("t1_pend", PENDING, 4'b0001);
      SRC_IRQ = '0; TIME = 7'd5; tick();
      chk("t1_irq", IRQ, 1); chk("t1_id", IRQ_ID, 0); chk("t1_stamp", IRQ_STAMP, 5);
      CPU_ACK = 1; tick(); CPU_ACK = 0;
      chk("t1_ackpend", PENDING, 0); chk("t1_flag_svc", INTFLAG, 1);
      CPU_EOI = 1; tick(); CPU_EOI = 0;
      chk("t1_flag_eoi", INTFLAG, 0);

      // Priority between simultaneous rises, with a gap between requests.
      wr_mask(4'b1111);
      SRC_IRQ = 4'b1010; tick(); SRC_IRQ = '0; tick();
      chk("t2_first", IRQ_ID, 1);
      ack_eoi();
      chk("t2_gap", IRQ, 0);
      tick();
      chk("t2_second_irq", IRQ, 1); chk("t2_second_id", IRQ_ID, 3);
      ack_eoi();

      // Pending while masked, released by a mask write.
      wr_mask(4'b0000);
      SRC_IRQ = 4'b0100; tick(); SRC_IRQ = '0; tick(); tick();
      chk("t3_masked", IRQ, 0); chk("t3_pend", PENDING[2], 1);
      wr_mask(4'b0100);
      chk("t3_lat1", IRQ, 0);
      tick();
      chk("t3_irq", IRQ, 1); chk("t3_id", IRQ_ID, 2);
      ack_eoi();

      // Withdrawal by clear, then set-beats-clear.
      wr_mask(4'b1111);
      SRC_IRQ = 4'b0010; tick(); SRC_IRQ = '0; tick();
      chk("t4_req", IRQ_ID, 1);
      CLR_WE = 1; CLR_WDATA = 4'b0010; tick(); CLR_WE = 0;
      tick();
      chk("t4_withdrawn", IRQ, 0);
      SRC_IRQ = 4'b0010; CLR_WE = 1; tick(); CLR_WE = 0;
      chk("t4_set_wins", PENDING[1], 1);
      SRC_IRQ = '0; tick();
      ack_eoi();
      tick(); tick();

      // Held level yields a single request.
      wr_mask(4'b0001);
      n_raise = 0;
      SRC_IRQ = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         CPU_ACK = m_asking; CPU_EOI = m_serving;
         tick();
      end
      quiet(); SRC_IRQ = '0; tick(); tick();
      chk("t5_one_req", n_raise, 1);

      // Reset in SERVICE with two sources pending.
      wr_mask(4'b1111);
      SRC_IRQ = 4'b1010; tick(); SRC_IRQ = '0; tick();
      CPU_ACK = 1; tick(); CPU_ACK = 0;
      SRC_IRQ = 4'b0010; tick();
      chk("t6_pend", PENDING, 4'b1010);
      RST = 1; SRC_IRQ = '0; tick(); RST = 0;
      chk("t6_pend0", PENDING, 0); chk("t6_mask0", MASK, 0); chk("t6_irq0", IRQ, 0);
      SRC_IRQ = 4'b0100; tick(); tick(); tick();
      chk("t6_noirq", IRQ, 0);
      wr_mask(4'b0100); tick();
      chk("t6_irq_after_mask", IRQ, 1);
      SRC_IRQ = '0; ack_eoi();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         RST        = ($urandom_range(0, 199) == 0);
         MASK_WE    = ($urandom_range(0, 19) == 0);
         MASK_WDATA = N'($urandom);
         CLR_WE     = ($urandom_range(0, 14) == 0);
         CLR_WDATA  = N'($urandom);
         CPU_ACK    = ($urandom_range(0, 3) == 0);
         CPU_EOI    = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) SRC_IRQ[b] = ~SRC_IRQ[b];
         if ($urandom_range(0, 3) == 0) TIME = 7'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
